// File: rtl/pulse_pkg.sv
// Shared constants for the navigation pulse modulator and decoder: direction
// codes, nominal pulse widths at the default clock, and the decoder FSM states.
package pulse_pkg;

    localparam logic [1:0] DIR_FWD = 2'd0;
    localparam logic [1:0] DIR_NEU = 2'd1;
    localparam logic [1:0] DIR_REV = 2'd2;

    localparam int unsigned DEF_CLK_RATE = 100_000_000;
    localparam int unsigned PW_FWD_NOM   = DEF_CLK_RATE / 1000;      // 1.0 ms
    localparam int unsigned PW_NEU_NOM   = DEF_CLK_RATE / 2000 * 3;  // 1.5 ms
    localparam int unsigned PW_REV_NOM   = DEF_CLK_RATE / 500;       // 2.0 ms

    localparam int unsigned CNT_W = 22;

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        HIGH
    } dec_state_t;

    // Inclusive thresholds on both sides; anything between is neutral.
    function automatic logic [1:0] classify(input logic [CNT_W-1:0] w,
                                            input logic [CNT_W-1:0] fwd_max,
                                            input logic [CNT_W-1:0] rev_min);
        if (w <= fwd_max)
            return DIR_FWD;
        else if (w >= rev_min)
            return DIR_REV;
        else
            return DIR_NEU;
    endfunction

endpackage

// File: rtl/pulse_glitch_filter.sv
// Level filter: the output follows the input only after the input has differed
// from it for GLITCH_CYCLES consecutive cycles, so both edges are delayed equally.
module pulse_glitch_filter #(
    parameter int unsigned GLITCH_CYCLES = 16,
    parameter logic        RST_LEVEL     = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic level_in,
    output logic level_out
);

    localparam int unsigned CW = $clog2(GLITCH_CYCLES + 1);

    logic [CW-1:0] run_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            level_out <= RST_LEVEL;
            run_q     <= '0;
        end else if (level_in == level_out) begin
            run_q <= '0;
        end else if (run_q == CW'(GLITCH_CYCLES - 1)) begin
            level_out <= level_in;
            run_q     <= '0;
        end else begin
            run_q <= run_q + 1'b1;
        end
    end

endmodule

// File: rtl/pulse_width_decoder.sv
// Servo/ESC pulse-width decoder: measures high time, classifies direction and
// flags timeouts. Define PULSE_DEC_FILTER_EN to insert the glitch filter.
module pulse_width_decoder
    import pulse_pkg::*;
#(
    parameter int unsigned CLK_RATE      = DEF_CLK_RATE,
    parameter int unsigned MIN_PULSE     = PW_FWD_NOM * 4 / 5,
    parameter int unsigned MAX_PULSE     = PW_REV_NOM * 11 / 10,
    parameter int unsigned FWD_MAX       = (PW_FWD_NOM + PW_NEU_NOM) / 2,
    parameter int unsigned REV_MIN       = (PW_NEU_NOM + PW_REV_NOM) / 2,
    parameter int unsigned TIMEOUT       = CLK_RATE / 1000 * 30,
    parameter int unsigned GLITCH_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PulseIn,
    output logic [20:0] Width,
    output logic [1:0]  Dir,
    output logic        Valid,
    output logic        Error,
    output logic        SignalLost
);

    localparam logic [CNT_W-1:0] MIN_W  = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_W  = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] FWD_W  = CNT_W'(FWD_MAX);
    localparam logic [CNT_W-1:0] REV_W  = CNT_W'(REV_MIN);
    localparam logic [CNT_W-1:0] TOUT_W = CNT_W'(TIMEOUT);

    // Empty block appears in the elaborated hierarchy only for an inconsistent configuration.
    if (!(MIN_PULSE <= FWD_MAX && FWD_MAX < REV_MIN && REV_MIN <= MAX_PULSE &&
          GLITCH_CYCLES > 0)) begin : g_invalid_config
    end

    logic [1:0] sync_q;
    logic       level;
    logic       prev_q;
    logic       rise;
    logic       fall;

    // Reset to high so a pulse already in progress at reset release is never seen as a rise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], PulseIn};
            prev_q <= level;
        end
    end

`ifdef PULSE_DEC_FILTER_EN
    pulse_glitch_filter #(
        .GLITCH_CYCLES (GLITCH_CYCLES),
        .RST_LEVEL     (1'b1)
    ) u_filter (
        .CLK       (CLK),
        .RST       (RST),
        .level_in  (sync_q[1]),
        .level_out (level)
    );
`else
    always_comb level = sync_q[1];
`endif

    always_comb begin
        rise = level & ~prev_q;
        fall = ~level & prev_q;
    end

    dec_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             eval_q, eval_d;
    logic             stuck_q, stuck_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= WAIT_LOW;
            cnt_q   <= '0;
            eval_q  <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            eval_q  <= eval_d;
            stuck_q <= stuck_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        eval_d  = 1'b0;
        stuck_d = 1'b0;
        case (state_q)
            WAIT_LOW: begin
                if (!level)
                    state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) begin
                    cnt_d   = CNT_W'(1);
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    eval_d  = 1'b1;
                    state_d = WAIT_RISE;
                end else if (cnt_q == MAX_W) begin
                    cnt_d   = MAX_W + 1'b1;
                    stuck_d = 1'b1;
                    state_d = WAIT_LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    logic             accept;
    logic [CNT_W-1:0] gap_q;

    always_comb accept = eval_q && (cnt_q >= MIN_W) && (cnt_q <= MAX_W);

    // cnt_q still holds the measured width while eval_q is set, even if the next rise is already seen.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Width      <= '0;
            Dir        <= DIR_NEU;
            Valid      <= 1'b0;
            Error      <= 1'b0;
            SignalLost <= 1'b1;
            gap_q      <= '0;
        end else begin
            Valid <= accept;
            Error <= (eval_q && !accept) || stuck_q;
            if (accept) begin
                Width      <= cnt_q[20:0];
                Dir        <= classify(cnt_q, FWD_W, REV_W);
                gap_q      <= '0;
                SignalLost <= 1'b0;
            end else if (gap_q >= TOUT_W - 1'b1) begin
                gap_q      <= TOUT_W;
                SignalLost <= 1'b1;
                Dir        <= DIR_NEU;
            end else begin
                gap_q <= gap_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Scoreboard bench for pulse_width_decoder with time-scaled parameters
// (all widths divided by 1000) so the run stays short.
module tb_pulse_width_decoder;

    localparam int unsigned T_MIN   = 80;
    localparam int unsigned T_MAX   = 220;
    localparam int unsigned T_FWD   = 125;
    localparam int unsigned T_REV   = 175;
    localparam int unsigned T_TOUT  = 3000;
    localparam int unsigned T_GLITCH = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PulseIn = 1'b0;
    logic [20:0] Width;
    logic [1:0]  Dir;
    logic        Valid;
    logic        Error;
    logic        SignalLost;

    pulse_width_decoder #(
        .CLK_RATE      (100_000),
        .MIN_PULSE     (T_MIN),
        .MAX_PULSE     (T_MAX),
        .FWD_MAX       (T_FWD),
        .REV_MIN       (T_REV),
        .TIMEOUT       (T_TOUT),
        .GLITCH_CYCLES (T_GLITCH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PulseIn    (PulseIn),
        .Width      (Width),
        .Dir        (Dir),
        .Valid      (Valid),
        .Error      (Error),
        .SignalLost (SignalLost)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit is_err;
        int w;
        int d;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic expect_evt(input bit is_err, input int w, input int d);
        exp_t e;
        e.is_err = is_err;
        e.w      = w;
        e.d      = d;
        expq.push_back(e);
    endtask

    task automatic drive_pulse(input int n, input int gap);
        @(posedge CLK);
        #1 PulseIn = 1'b1;
        repeat (n) @(posedge CLK);
        #1 PulseIn = 1'b0;
        repeat (gap) @(posedge CLK);
    endtask

    // Monitor: every Valid/Error strobe must match the oldest pending expectation.
    always @(negedge CLK) begin
        if (!RST && (Valid || Error)) begin
            if (expq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got Valid=%0d Error=%0d Width=%0d, expected none (t=%0t)",
                         Valid, Error, Width, $time);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("exclusive", int'(Valid & Error), 0);
                chk("is_error", int'(Error), int'(e.is_err));
                chk("width", int'(Width), e.w);
                chk("dir", int'(Dir), e.d);
            end
        end
    end

    // Directed vectors: pulse length, trailing idle, expected kind and Width/Dir after it.
    int vn[15]   = '{100, 150, 200, 125, 126, 174, 175,  80,  79, 220, 221,   5, 300, 150, 100};
    int vg[15]   = '{ 30,  30,  30,  30,  30,  30,  30,  30,  30,  30,  30,  30,  30,  30,   0};
    int verr[15] = '{  0,   0,   0,   0,   0,   0,   0,   0,   1,   0,   1,   1,   1,   0,   0};
    int vw[15]   = '{100, 150, 200, 125, 126, 174, 175,  80,  80, 220, 220, 220, 220, 150, 100};
    int vd[15]   = '{  0,   1,   2,   0,   1,   1,   2,   0,   0,   2,   2,   2,   2,   1,   0};

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_width", int'(Width), 0);
        chk("rst_dir", int'(Dir), 1);
        chk("rst_valid", int'(Valid), 0);
        chk("rst_error", int'(Error), 0);
        chk("rst_lost", int'(SignalLost), 1);
        @(posedge CLK);
        #1 RST = 1'b0;
        repeat (10) @(posedge CLK);

        for (int i = 0; i < 15; i++) begin
            expect_evt(verr[i] != 0, vw[i], vd[i]);
            drive_pulse(vn[i], vg[i]);
            if (i == 0) begin
                @(negedge CLK);
                chk("lost_cleared", int'(SignalLost), 0);
            end
        end

        // Follows the 100-cycle pulse after a single low sample.
        expect_evt(1'b0, 200, 2);
        drive_pulse(200, 30);

`ifdef PULSE_DEC_FILTER_EN
        expect_evt(1'b0, 150, 1);
        @(posedge CLK);
        #1 PulseIn = 1'b1;
        repeat (70) @(posedge CLK);
        #1 PulseIn = 1'b0;
        repeat (10) @(posedge CLK);
        #1 PulseIn = 1'b1;
        repeat (70) @(posedge CLK);
        #1 PulseIn = 1'b0;
        repeat (30 + T_GLITCH) @(posedge CLK);
`endif

        // Timeout: last valid 200 pulse, then a long low stretch.
        expect_evt(1'b0, 200, 2);
        drive_pulse(200, 10);
        @(negedge CLK);
        chk("pre_timeout_lost", int'(SignalLost), 0);
        chk("pre_timeout_dir", int'(Dir), 2);
        repeat (T_TOUT) @(posedge CLK);
        @(negedge CLK);
        chk("timeout_lost", int'(SignalLost), 1);
        chk("timeout_dir", int'(Dir), 1);
        chk("timeout_width", int'(Width), 200);

        // Reset mid-pulse and released while PulseIn is still high.
        chk("pending_before_reset", expq.size(), 0);
        @(posedge CLK);
        #1 PulseIn = 1'b1;
        repeat (50) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (100) @(posedge CLK);
        #1 PulseIn = 1'b0;
        repeat (20) @(posedge CLK);
        @(negedge CLK);
        chk("post_reset_width", int'(Width), 0);
        chk("post_reset_lost", int'(SignalLost), 1);
        chk("post_reset_dir", int'(Dir), 1);

        expect_evt(1'b0, 150, 1);
        drive_pulse(150, 30);
        @(negedge CLK);
        chk("after_reset_lost", int'(SignalLost), 0);

        for (int k = 0; k < 200 && expq.size() != 0; k++) @(posedge CLK);
        chk("queue_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
